pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Parametrised program-counter sequencer for the 5-stage pipeline's IF stage. It replaces the bare load/hold PC register with several additions:
- a run-control state machine;
- stall hold;
- redirect for branch and jump;
- a circular return-address stack (RAS) for call/return;
- a registered `pc` that never goes high-impedance.

Downstream, the instruction memory address and the IF/ID pipeline register consume `pc` and `pc_valid`.

## Interface
- `AW`, 13: PC/address width in bits.
- `STEP`, 1: sequential increment, in address units.
- `RESET_ADDR`, 0: PC value loaded on reset.
- `RAS_DEPTH`, 4: number of return-stack entries; must be ≥2.
- `RAS_CW`, 3: width of `ras_count`; must satisfy 2^RAS_CW > RAS_DEPTH.
- `clk`  in  1  system clock; rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  level; moves IDLE to RUN.
- `stall`  in  1  hold PC; hazard unit.
- `halt`  in  1  moves RUN to HALT.
- `resume`  in  1  moves HALT to RUN.
- `redirect`  in  1  taken branch/jump, resolved in EX.
- `redirect_addr`  in  AW  target for redirect and call; fallback target for ret.
- `call`  in  1  push `link_addr` and go to `redirect_addr`.
- `ret`  in  1  pop the RAS and go to the popped address.
- `link_addr`  in  AW  return address to push on call.
- `pc`  out  AW  current fetch address; registered.
- `pc_valid`  out  1  fetch at `pc` is to be issued this cycle.
- `ras_count`  out  RAS_CW  number of valid RAS entries.
- `ras_empty`, `ras_full`  out  1  flags, decoded from `ras_count`.
- `ras_err`  out  1  sticky overflow/underflow flag.

## Operation
- States: IDLE, RUN, HALT. Reset enters IDLE.
- **IDLE to RUN:** at an edge where `start`=1. `pc` stays RESET_ADDR.
- **RUN to HALT:** at an edge where `halt`=1. That edge's flow event (if any) still updates `pc`.
- **HALT to RUN:** at an edge where `resume`=1. `pc` is unchanged.
- In IDLE and HALT:
  - `pc` holds its value.
  - `redirect`, `call`, `ret` are ignored, and the RAS is unchanged.
- `pc_valid` = (state==RUN) && !`stall`. It is combinational from state.
- Next-PC priority in RUN, highest first:
  1. `ret`&&`call`: next `pc` = top of stack; top entry replaced by `link_addr`; count unchanged. When the RAS is empty: `link_addr` is pushed, `pc` = `redirect_addr`, `ras_err` set.
  2. `ret`: pop; `pc` = popped entry. When empty: `pc` = `redirect_addr`, count stays 0, `ras_err` set.
  3. `call`: push `link_addr`; `pc` = `redirect_addr`.
  4. `redirect`: `pc` = `redirect_addr`.
  5. `stall`: `pc` holds.
  6. Otherwise: `pc` = (`pc` + STEP) mod 2^AW. Wraps silently.
- Flow events (priorities 1–4) apply even when `stall`=1. Flush wins over hazard.
- RAS is a circular buffer with a top pointer.
  - Push when full overwrites the oldest entry. Count stays RAS_DEPTH and `ras_err` is set.
  - Pop decrements the count and pointer modulo RAS_DEPTH.
- `ras_err` clears only on reset.

## Timing
- Reset (asynchronous, `reset`=0) forces, immediately and without waiting for a clock edge:
  - `pc`=RESET_ADDR;
  - state=IDLE, so `pc_valid`=0;
  - `ras_count`=0, `ras_empty`=1, `ras_full`=0, `ras_err`=0.
- Reset asserted mid-run aborts any in-flight event. Deassertion is synchronised by the system. The first active edge after release samples normally.
- All inputs are sampled at the rising edge. Latency is 1 cycle: an event at edge N is visible on `pc` after edge N.
- First fetch timing:
  - `start` sampled at edge 0: `pc_valid`=1 from edge 0 with `pc`=RESET_ADDR.
  - `pc`=RESET_ADDR+STEP after edge 1.
- A pop followed by a push in consecutive cycles is fully supported. There are no bubbles.
- Each popped value is the value pushed most recently and not yet popped. This holds for up to RAS_DEPTH outstanding calls.

## Test plan
- **Reset and start:** reset low mid-cycle, then release; `start`=1 for 1 cycle; run 4 cycles. Expect `pc` 0, 0, 1, 2, 3, 4. `pc_valid` is 0 before `start` and 1 after.
- **Wrap-around:** AW=13, STEP=1, redirect to 0x1FFE, then run free. Expect `pc` 0x1FFE, 0x1FFF, 0x0000.
- **Stall versus redirect:** hold `stall` for 3 cycles at `pc`=5. Expect `pc` holds 5 and `pc_valid`=0. Then in a stall cycle assert `redirect` with `redirect_addr`=0x40. Expect `pc`=0x40 after that edge.
- **Nested calls:** 4 calls with link 0x10/0x20/0x30/0x40, then 4 rets. Expect `pc` 0x40, 0x30, 0x20, 0x10. `ras_full` is 1 after the 4th call, `ras_empty` is 1 at the end, and `ras_err`=0.
- **Overflow and underflow:** 5 calls with links 1..5, then 5 rets, with `redirect_addr`=0x77 on the 5th ret. Expect pops 5, 4, 3, 2, then `pc`=0x77. `ras_err` is 1 from the 5th call onward.
- **Halt, simultaneous call and ret, reset mid-run:**
  - Assert `halt` at `pc`=9. Expect `pc` holds 10, and `redirect` is ignored. `resume` continues 11, 12.
  - With top=0x30, assert `call`+`ret` with `link_addr`=0x55. Expect `pc`=0x30, top=0x55, and count unchanged.
  - Reset mid-run. Expect `pc`=0 immediately.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Fetch-side bundle for pc_sequencer: run control, flow events,
// and the registered PC / return-stack status.
interface pc_sequencer_if #(
   parameter int AW     = 13,
   parameter int RAS_CW = 3
);
   logic          start;
   logic          stall;
   logic          halt;
   logic          resume;
   logic          redirect;
   logic [AW-1:0] redirect_addr;
   logic          call;
   logic          ret;
   logic [AW-1:0] link_addr;
   logic [AW-1:0] pc;
   logic          pc_valid;
   logic [RAS_CW-1:0] ras_count;
   logic          ras_empty;
   logic          ras_full;
   logic          ras_err;

   modport master (
      output start, stall, halt, resume,
      output redirect, redirect_addr,
      output call, ret, link_addr,
      input  pc, pc_valid, ras_count,
      input  ras_empty, ras_full, ras_err
   );

   modport slave (
      input  start, stall, halt, resume,
      input  redirect, redirect_addr,
      input  call, ret, link_addr,
      output pc, pc_valid, ras_count,
      output ras_empty, ras_full, ras_err
   );
endinterface

// File: rtl/pc_sequencer.sv
// IF-stage program counter: run control, stall hold, redirect,
// and a circular return-address stack for call/return.
module pc_sequencer #(
   parameter int AW         = 13,
   parameter int STEP       = 1,
   parameter int RESET_ADDR = 0,
   parameter int RAS_DEPTH  = 4,
   parameter int RAS_CW     = 3
) (
   input logic           clk,
   input logic           reset,
   pc_sequencer_if.slave bus
);
   localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [AW-1:0]     pc_q, pc_d;
   logic [AW-1:0]     mem_q [RAS_DEPTH];
   logic [AW-1:0]     mem_d [RAS_DEPTH];
   logic [PW-1:0]     top_q, top_d;
   logic [RAS_CW-1:0] cnt_q, cnt_d;
   logic              err_q, err_d;
   logic              empty, full;

   function automatic logic [PW-1:0] ptr_inc(
      input logic [PW-1:0] p
   );
      return (p == PW'(RAS_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   function automatic logic [PW-1:0] ptr_dec(
      input logic [PW-1:0] p
   );
      return (p == '0) ? PW'(RAS_DEPTH - 1) : p - 1'b1;
   endfunction

   assign empty = (cnt_q == '0);
   assign full  = (cnt_q == RAS_CW'(RAS_DEPTH));

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      mem_d   = mem_q;
      top_d   = top_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      unique case (state_q)
         IDLE: if (bus.start) state_d = RUN;
         HALT: if (bus.resume) state_d = RUN;
         RUN: begin
            if (bus.halt) state_d = HALT;
            if (bus.call && bus.ret && !empty) begin
               pc_d         = mem_q[top_q];
               mem_d[top_q] = bus.link_addr;
            end else if (bus.ret && !bus.call) begin
               if (empty) begin
                  pc_d  = bus.redirect_addr;
                  err_d = 1'b1;
               end else begin
                  pc_d  = mem_q[top_q];
                  top_d = ptr_dec(top_q);
                  cnt_d = cnt_q - 1'b1;
               end
            end else if (bus.call) begin
              // covers call alone and call+ret on an empty stack
               top_d        = ptr_inc(top_q);
               mem_d[top_d] = bus.link_addr;
               pc_d         = bus.redirect_addr;
               if (full) err_d = 1'b1;
               else      cnt_d = cnt_q + 1'b1;
               if (bus.ret) err_d = 1'b1;
            end else if (bus.redirect) begin
               pc_d = bus.redirect_addr;
            end else if (!bus.stall) begin
               pc_d = pc_q + AW'(STEP);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         pc_q    <= AW'(RESET_ADDR);
         top_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         for (int i = 0; i < RAS_DEPTH; i++)
            mem_q[i] <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         top_q   <= top_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         mem_q   <= mem_d;
      end
   end

   assign bus.pc        = pc_q;
   assign bus.pc_valid  = (state_q == RUN) && !bus.stall;
   assign bus.ras_count = cnt_q;
   assign bus.ras_empty = empty;
   assign bus.ras_full  = full;
   assign bus.ras_err   = err_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with hand-computed
// expectations checked by immediate assertions.
module tb_pc_sequencer;
   logic clk;
   logic reset;
   int   checks;
   int   errors;

   pc_sequencer_if #(.AW(13), .RAS_CW(3)) bus ();

   pc_sequencer #(
      .AW(13), .STEP(1), .RESET_ADDR(0),
      .RAS_DEPTH(4), .RAS_CW(3)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(
      input string       tag,
      input logic [31:0] obs,
      input logic [31:0] exp
   );
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      bus.start         = 1'b0;
      bus.stall         = 1'b0;
      bus.halt          = 1'b0;
      bus.resume        = 1'b0;
      bus.redirect      = 1'b0;
      bus.redirect_addr = '0;
      bus.call          = 1'b0;
      bus.ret           = 1'b0;
      bus.link_addr     = '0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b1;
      idle_in();

      #3 reset = 1'b0;
      #1;
      chk("rst_pc", 32'(bus.pc), 32'h0);
      chk("rst_valid", 32'(bus.pc_valid), 32'h0);
      chk("rst_cnt", 32'(bus.ras_count), 32'h0);
      chk("rst_empty", 32'(bus.ras_empty), 32'h1);
      chk("rst_full", 32'(bus.ras_full), 32'h0);
      chk("rst_err", 32'(bus.ras_err), 32'h0);
      @(negedge clk);
      reset = 1'b1;

      tick();
      chk("idle_pc", 32'(bus.pc), 32'h0);
      chk("idle_valid", 32'(bus.pc_valid), 32'h0);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      chk("start_pc", 32'(bus.pc), 32'h0);
      chk("start_valid", 32'(bus.pc_valid), 32'h1);
      for (int i = 1; i <= 5; i++) begin
         tick();
         chk("run_pc", 32'(bus.pc), 32'(i));
      end

      bus.stall = 1'b1;
      #1;
      chk("stall_valid", 32'(bus.pc_valid), 32'h0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_pc", 32'(bus.pc), 32'h5);
      end
      bus.redirect      = 1'b1;
      bus.redirect_addr = 13'h040;
      tick();
      chk("stall_redir", 32'(bus.pc), 32'h40);
      idle_in();

      bus.redirect      = 1'b1;
      bus.redirect_addr = 13'h1FFE;
      tick();
      idle_in();
      chk("wrap0", 32'(bus.pc), 32'h1FFE);
      tick();
      chk("wrap1", 32'(bus.pc), 32'h1FFF);
      tick();
      chk("wrap2", 32'(bus.pc), 32'h0000);

      for (int i = 1; i <= 4; i++) begin
         bus.call          = 1'b1;
         bus.link_addr     = 13'(i * 16);
         bus.redirect_addr = 13'h100 + 13'(i);
         tick();
         chk("call_pc", 32'(bus.pc), 32'h100 + 32'(i));
         chk("call_cnt", 32'(bus.ras_count), 32'(i));
      end
      idle_in();
      chk("nest_full", 32'(bus.ras_full), 32'h1);
      for (int i = 4; i >= 1; i--) begin
         bus.ret           = 1'b1;
         bus.redirect_addr = 13'h7FF;
         tick();
         chk("ret_pc", 32'(bus.pc), 32'(i * 16));
      end
      idle_in();
      chk("nest_empty", 32'(bus.ras_empty), 32'h1);
      chk("nest_err", 32'(bus.ras_err), 32'h0);

      bus.redirect      = 1'b1;
      bus.redirect_addr = 13'h009;
      tick();
      bus.redirect = 1'b0;
      chk("h_pc9", 32'(bus.pc), 32'h9);
      bus.halt = 1'b1;
      tick();
      bus.halt = 1'b0;
      chk("halt_pc", 32'(bus.pc), 32'hA);
      chk("halt_valid", 32'(bus.pc_valid), 32'h0);
      bus.redirect      = 1'b1;
      bus.redirect_addr = 13'h200;
      bus.call          = 1'b1;
      bus.link_addr     = 13'h111;
      tick();
      idle_in();
      chk("halt_ign", 32'(bus.pc), 32'hA);
      chk("halt_ras", 32'(bus.ras_count), 32'h0);
      bus.resume = 1'b1;
      tick();
      bus.resume = 1'b0;
      chk("resume_pc", 32'(bus.pc), 32'hA);
      chk("resume_valid", 32'(bus.pc_valid), 32'h1);
      tick();
      chk("resume_11", 32'(bus.pc), 32'hB);
      tick();
      chk("resume_12", 32'(bus.pc), 32'hC);

      bus.call          = 1'b1;
      bus.link_addr     = 13'h030;
      bus.redirect_addr = 13'h300;
      tick();
      chk("cr_push", 32'(bus.pc), 32'h300);
      bus.ret           = 1'b1;
      bus.link_addr     = 13'h055;
      bus.redirect_addr = 13'h123;
      tick();
      idle_in();
      chk("cr_pc", 32'(bus.pc), 32'h30);
      chk("cr_cnt", 32'(bus.ras_count), 32'h1);
      bus.ret = 1'b1;
      tick();
      idle_in();
      chk("cr_top", 32'(bus.pc), 32'h55);
      chk("cr_empty", 32'(bus.ras_empty), 32'h1);
      chk("cr_err", 32'(bus.ras_err), 32'h0);

      for (int i = 1; i <= 5; i++) begin
         bus.call          = 1'b1;
         bus.link_addr     = 13'(i);
         bus.redirect_addr = 13'h100;
         tick();
         chk("ovf_err", 32'(bus.ras_err), 32'(i == 5));
      end
      idle_in();
      chk("ovf_cnt", 32'(bus.ras_count), 32'h4);
      for (int i = 5; i >= 2; i--) begin
         bus.ret           = 1'b1;
         bus.redirect_addr = 13'h7FF;
         tick();
         chk("ovf_pop", 32'(bus.pc), 32'(i));
      end
      bus.redirect_addr = 13'h077;
      tick();
      idle_in();
      chk("udf_pc", 32'(bus.pc), 32'h77);
      chk("udf_cnt", 32'(bus.ras_count), 32'h0);
      chk("udf_err", 32'(bus.ras_err), 32'h1);

      bus.call          = 1'b1;
      bus.ret           = 1'b1;
      bus.link_addr     = 13'h066;
      bus.redirect_addr = 13'h088;
      tick();
      idle_in();
      chk("cre_pc", 32'(bus.pc), 32'h88);
      chk("cre_cnt", 32'(bus.ras_count), 32'h1);
      bus.ret = 1'b1;
      tick();
      idle_in();
      chk("cre_pop", 32'(bus.pc), 32'h66);

      tick();
      chk("pre_rst", 32'(bus.pc), 32'h67);
      #2 reset = 1'b0;
      #1;
      chk("mid_rst_pc", 32'(bus.pc), 32'h0);
      chk("mid_rst_valid", 32'(bus.pc_valid), 32'h0);
      chk("mid_rst_err", 32'(bus.ras_err), 32'h0);
      @(negedge clk);
      reset = 1'b1;
      tick();
      chk("post_rst_pc", 32'(bus.pc), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
